memory_bus_arbiter: RTL and testbench

Shares the single-port main memory between the processor's bus requesters: instruction fetch, microcode-driven data access and the debug/loader port. It grants one transaction at a time using round-robin order and drives the memory's enable, write-enable, address and write-data lines. It returns read data to the winner with a one-cycle acknowledge. It sits between the execution core and the memory macro and honours the core's halt line by refusing new grants.

---
 rtl/memory_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ bus requesters.
// One transaction at a time; every output comes straight from a register.
module memory_bus_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          halt,
   input  logic [NUM_REQ-1:0]            request,
   input  logic [NUM_REQ-1:0]            request_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] request_address,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] request_write_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            acknowledge,
   output logic [DATA_WIDTH-1:0]         read_data,
   output logic                          busy,
   output logic                          mem_enable,
   output logic                          mem_write_enable,
   output logic [ADDR_WIDTH-1:0]         mem_address,
   output logic [DATA_WIDTH-1:0]         mem_write_data,
   input  logic [DATA_WIDTH-1:0]         mem_read_data
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   localparam logic [PTR_W-1:0]   PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]   LAST_IDX  = PTR_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   WAIT_LOAD = CNT_W'(MEM_LATENCY - 1);
   localparam logic [NUM_REQ-1:0] REQ_ZERO  = {NUM_REQ{1'b0}};
   localparam logic [NUM_REQ-1:0] REQ_ONE   = NUM_REQ'(1'b1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t                state_r, state_s;
   logic [PTR_W-1:0]      winner_r, winner_s;
   logic [PTR_W-1:0]      rr_pointer_r, rr_pointer_s;
   logic [CNT_W-1:0]      wait_count_r, wait_count_s;
   logic                  write_flag_r, write_flag_s;
   logic [PTR_W-1:0]      pick_s;
   logic [NUM_REQ-1:0]    grant_s;
   logic [NUM_REQ-1:0]    acknowledge_s;
   logic [DATA_WIDTH-1:0] read_data_s;
   logic                  busy_s;
   logic                  mem_enable_s;
   logic                  mem_write_enable_s;
   logic [ADDR_WIDTH-1:0] mem_address_s;
   logic [DATA_WIDTH-1:0] mem_write_data_s;

   // First set request bit at or above ptr, wrapping; lowest offset wins.
   function automatic logic [PTR_W-1:0] pick_next(input logic [NUM_REQ-1:0] req,
                                                  input logic [PTR_W-1:0]   ptr);
      int k;
      pick_next = ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         k = (int'(ptr) + i) % NUM_REQ;
         if (req[k]) begin
            pick_next = PTR_W'(k);
         end
      end
   endfunction

   assign pick_s = pick_next(request, rr_pointer_r);

   // Next-state and next-output logic; outputs are registered below.
   always_comb begin
      state_s            = state_r;
      winner_s           = winner_r;
      rr_pointer_s       = rr_pointer_r;
      wait_count_s       = wait_count_r;
      write_flag_s       = write_flag_r;
      grant_s            = grant;
      acknowledge_s      = REQ_ZERO;
      read_data_s        = read_data;
      mem_enable_s       = 1'b0;
      mem_write_enable_s = 1'b0;
      mem_address_s      = mem_address;
      mem_write_data_s   = mem_write_data;

      case (state_r)
         IDLE: begin
            if (!halt && (request != REQ_ZERO)) begin
               state_s            = ISSUE;
               winner_s           = pick_s;
               grant_s            = REQ_ONE << pick_s;
               write_flag_s       = request_write[pick_s];
               mem_enable_s       = 1'b1;
               mem_write_enable_s = request_write[pick_s];
               mem_address_s      = request_address[int'(pick_s)*ADDR_WIDTH +: ADDR_WIDTH];
               mem_write_data_s   = request_write_data[int'(pick_s)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (write_flag_r) begin
               state_s       = ACK;
               acknowledge_s = grant;
            end else begin
               state_s      = WAIT;
               wait_count_s = WAIT_LOAD;
            end
         end
         WAIT: begin
            if (wait_count_r != CNT_ZERO) begin
               wait_count_s = wait_count_r - CNT_W'(1'b1);
            end else begin
               read_data_s   = mem_read_data;
               state_s       = ACK;
               acknowledge_s = grant;
            end
         end
         ACK: begin
            state_s = IDLE;
            grant_s = REQ_ZERO;
            if (winner_r == LAST_IDX) begin
               rr_pointer_s = PTR_ZERO;
            end else begin
               rr_pointer_s = winner_r + PTR_W'(1'b1);
            end
         end
         default: begin
            state_s = IDLE;
            grant_s = REQ_ZERO;
         end
      endcase

      busy_s = (state_s != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r          <= IDLE;
         winner_r         <= PTR_ZERO;
         rr_pointer_r     <= PTR_ZERO;
         wait_count_r     <= CNT_ZERO;
         write_flag_r     <= 1'b0;
         grant            <= REQ_ZERO;
         acknowledge      <= REQ_ZERO;
         read_data        <= {DATA_WIDTH{1'b0}};
         busy             <= 1'b0;
         mem_enable       <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_address      <= {ADDR_WIDTH{1'b0}};
         mem_write_data   <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r          <= state_s;
         winner_r         <= winner_s;
         rr_pointer_r     <= rr_pointer_s;
         wait_count_r     <= wait_count_s;
         write_flag_r     <= write_flag_s;
         grant            <= grant_s;
         acknowledge      <= acknowledge_s;
         read_data        <= read_data_s;
         busy             <= busy_s;
         mem_enable       <= mem_enable_s;
         mem_write_enable <= mem_write_enable_s;
         mem_address      <= mem_address_s;
         mem_write_data   <= mem_write_data_s;
      end
   end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: a latency-2 instance with a memory model
// and a latency-1 instance with a fixed-pattern read source.
module tb_memory_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt;
   logic [2:0]  req, req_wr;
   logic [47:0] req_addr;
   logic [23:0] req_wdata;
   logic [2:0]  grant, acknowledge;
   logic [7:0]  read_data, mem_write_data, mem_read_data;
   logic        busy, mem_enable, mem_write_enable;
   logic [15:0] mem_address;

   logic [2:0]  r1_req, r1_wr, grant1, ack1;
   logic [47:0] r1_addr;
   logic [23:0] r1_wdata;
   logic [7:0]  read_data1, mem_write_data1, rd1;
   logic        busy1, mem_enable1, mem_write_enable1;
   logic [15:0] mem_address1;

   logic [7:0]  mem [0:65535];
   logic [7:0]  rd_pipe0, rd_pipe1;
   logic        bd_we;
   logic [15:0] bd_addr;
   logic [7:0]  bd_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_bus_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(2)) dut (
      .clock(clk), .reset(reset), .halt(halt), .request(req), .request_write(req_wr),
      .request_address(req_addr), .request_write_data(req_wdata), .grant(grant),
      .acknowledge(acknowledge), .read_data(read_data), .busy(busy), .mem_enable(mem_enable),
      .mem_write_enable(mem_write_enable), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data));

   memory_bus_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(1)) dut1 (
      .clock(clk), .reset(reset), .halt(1'b0), .request(r1_req), .request_write(r1_wr),
      .request_address(r1_addr), .request_write_data(r1_wdata), .grant(grant1),
      .acknowledge(ack1), .read_data(read_data1), .busy(busy1), .mem_enable(mem_enable1),
      .mem_write_enable(mem_write_enable1), .mem_address(mem_address1),
      .mem_write_data(mem_write_data1), .mem_read_data(rd1));

   // Latency-2 memory: read data appears two cycles after the enable cycle.
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (mem_enable && mem_write_enable) mem[mem_address] <= mem_write_data;
      if (mem_enable && !mem_write_enable) rd_pipe0 <= mem[mem_address];
      rd_pipe1 <= rd_pipe0;
   end
   assign mem_read_data = rd_pipe1;

   // Latency-1 source for the second instance: data = low address byte ^ 0x3C.
   always @(posedge clk) begin
      if (mem_enable1 && !mem_write_enable1) rd1 <= mem_address1[7:0] ^ 8'h3C;
   end

   task automatic run_single(input int idx, input logic wr, input logic [15:0] addr,
                             input logic [7:0] wdata, input logic [7:0] exp_rd);
      logic [2:0] oh;
      int lat;
      oh  = 3'b001 << idx;
      lat = wr ? 1 : 3;
      req = oh;
      req_wr = wr ? oh : 3'b000;
      req_addr[idx*16 +: 16] = addr;
      req_wdata[idx*8 +: 8]  = wdata;
      @(negedge clk);
      req = 3'b000;
      checks++; if (grant !== oh) begin errors++; $display("FAIL txn_grant: got %b expected %b", grant, oh); end
      checks++; if (mem_enable !== 1'b1) begin errors++; $display("FAIL txn_mem_enable: got %b expected 1", mem_enable); end
      checks++; if (mem_write_enable !== wr) begin errors++; $display("FAIL txn_mem_we: got %b expected %b", mem_write_enable, wr); end
      checks++; if (mem_address !== addr) begin errors++; $display("FAIL txn_mem_address: got %h expected %h", mem_address, addr); end
      if (wr) begin
         checks++; if (mem_write_data !== wdata) begin errors++; $display("FAIL txn_mem_wdata: got %h expected %h", mem_write_data, wdata); end
      end
      for (int n = 1; n <= lat; n++) begin
         @(negedge clk);
         checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL txn_enable_low: got %b expected 0", mem_enable); end
         if (n < lat) begin
            checks++; if (acknowledge !== 3'b000) begin errors++; $display("FAIL txn_early_ack: got %b expected 000", acknowledge); end
         end else begin
            checks++; if (acknowledge !== oh) begin errors++; $display("FAIL txn_ack: got %b expected %b", acknowledge, oh); end
            checks++; if (read_data !== exp_rd) begin errors++; $display("FAIL txn_read_data: got %h expected %h", read_data, exp_rd); end
            checks++; if (grant !== oh) begin errors++; $display("FAIL txn_grant_ack: got %b expected %b", grant, oh); end
         end
      end
      @(negedge clk);
      checks++;
      if (grant !== 3'b000 || acknowledge !== 3'b000 || busy !== 1'b0) begin
         errors++; $display("FAIL txn_release: got grant=%b ack=%b busy=%b expected 000/000/0", grant, acknowledge, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; halt = 1'b0; bd_we = 1'b0; bd_addr = 16'h0000; bd_data = 8'h00;
      req = 3'b000; req_wr = 3'b000; req_addr = 48'h0; req_wdata = 24'h0;
      r1_req = 3'b000; r1_wr = 3'b000; r1_addr = 48'h0; r1_wdata = 24'h0;
      repeat (2) @(negedge clk);
      checks++;
      if ({grant, acknowledge, read_data, busy, mem_enable, mem_write_enable, mem_address, mem_write_data} !== 41'h0) begin
         errors++; $display("FAIL reset_outputs: got %b/%b/%h/%b/%b/%b/%h/%h expected all zero",
                            grant, acknowledge, read_data, busy, mem_enable, mem_write_enable, mem_address, mem_write_data);
      end
      checks++;
      if ({grant1, ack1, read_data1, busy1} !== 15'h0) begin
         errors++; $display("FAIL reset_outputs_lat1: got %b/%b/%h/%b expected zero", grant1, ack1, read_data1, busy1);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read();
      bd_we = 1'b1; bd_addr = 16'h0040; bd_data = 8'hA5;
      @(negedge clk);
      bd_we = 1'b0;
      run_single(1, 1'b0, 16'h0040, 8'h00, 8'hA5);
   endtask

   task automatic test_round_robin();
      int k, w;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req = 3'b111; req_wr = 3'b111;
      req_addr  = {16'h3002, 16'h2001, 16'h1000};
      req_wdata = {8'h33, 8'h22, 8'h11};
      for (int t = 1; t <= 13; t++) begin
         @(negedge clk);
         k = (t - 1) / 3;
         w = k % 3;
         if (t == 13) begin
            checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rr_stop: got %b expected 000", grant); end
         end else if ((t - 1) % 3 == 0) begin
            checks++; if (grant !== (3'b001 << w)) begin errors++; $display("FAIL rr_grant: got %b expected %b", grant, 3'b001 << w); end
            checks++; if (mem_address !== 16'h1000 + 16'(w) * 16'h1001) begin errors++; $display("FAIL rr_address: got %h expected %h", mem_address, 16'h1000 + 16'(w) * 16'h1001); end
            checks++; if (mem_write_data !== 8'h11 * 8'(w + 1)) begin errors++; $display("FAIL rr_wdata: got %h expected %h", mem_write_data, 8'h11 * 8'(w + 1)); end
         end else if ((t - 1) % 3 == 1) begin
            checks++; if (acknowledge !== (3'b001 << w)) begin errors++; $display("FAIL rr_ack: got %b expected %b", acknowledge, 3'b001 << w); end
            if (t == 11) req = 3'b000;
         end else begin
            checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rr_idle_gap: got %b expected 000", grant); end
         end
      end
      checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL rr_read_data_kept: got %h expected 00", read_data); end
      checks++; if (mem[16'h2001] !== 8'h22) begin errors++; $display("FAIL rr_mem_write: got %h expected 22", mem[16'h2001]); end
   endtask

   task automatic test_write_then_read();
      run_single(2, 1'b1, 16'h1234, 8'h5A, 8'h00);
      run_single(0, 1'b0, 16'h1234, 8'h00, 8'h5A);
   endtask

   task automatic test_halt();
      req = 3'b001; req_wr = 3'b011;
      req_addr  = {16'h0000, 16'h0600, 16'h0500};
      req_wdata = {8'h00, 8'h88, 8'h77};
      @(negedge clk);
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL halt_first_grant: got %b expected 001", grant); end
      halt = 1'b1; req = 3'b011;
      @(negedge clk);
      checks++; if (acknowledge !== 3'b001) begin errors++; $display("FAIL halt_ack_inflight: got %b expected 001", acknowledge); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (grant !== 3'b000 || mem_enable !== 1'b0) begin errors++; $display("FAIL halt_blocks: got grant=%b en=%b expected 000/0", grant, mem_enable); end
      end
      halt = 1'b0; req = 3'b010;
      @(negedge clk);
      req = 3'b000;
      checks++; if (grant !== 3'b010) begin errors++; $display("FAIL halt_resume_grant: got %b expected 010", grant); end
      checks++; if (mem_address !== 16'h0600) begin errors++; $display("FAIL halt_resume_addr: got %h expected 0600", mem_address); end
      @(negedge clk);
      checks++; if (acknowledge !== 3'b010) begin errors++; $display("FAIL halt_resume_ack: got %b expected 010", acknowledge); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      req = 3'b010; req_wr = 3'b000; req_addr[31:16] = 16'h0040;
      @(negedge clk);
      req = 3'b000;
      checks++; if (grant !== 3'b010) begin errors++; $display("FAIL rst_mid_grant: got %b expected 010", grant); end
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({grant, acknowledge, read_data, busy, mem_enable, mem_write_enable, mem_address, mem_write_data} !== 41'h0) begin
         errors++; $display("FAIL rst_mid_outputs: got %b/%b/%h/%b/%b/%b/%h/%h expected all zero",
                            grant, acknowledge, read_data, busy, mem_enable, mem_write_enable, mem_address, mem_write_data);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (acknowledge !== 3'b000) begin errors++; $display("FAIL rst_mid_no_ack: got %b expected 000", acknowledge); end
      end
      req = 3'b110; req_wr = 3'b110;
      req_addr  = {16'h0800, 16'h0700, 16'h0000};
      req_wdata = {8'hAA, 8'h99, 8'h00};
      @(negedge clk);
      checks++; if (grant !== 3'b010) begin errors++; $display("FAIL rst_mid_ptr0: got %b expected 010", grant); end
      req = 3'b100;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      req = 3'b000;
      checks++; if (grant !== 3'b100 || mem_address !== 16'h0800) begin errors++; $display("FAIL rst_mid_req2: got %b/%h expected 100/0800", grant, mem_address); end
      @(negedge clk);
      checks++; if (acknowledge !== 3'b100) begin errors++; $display("FAIL rst_mid_req2_ack: got %b expected 100", acknowledge); end
      @(negedge clk);
   endtask

   task automatic test_latency1();
      r1_req = 3'b001; r1_wr = 3'b000; r1_addr[15:0] = 16'h0011;
      @(negedge clk);
      r1_req = 3'b000;
      checks++; if (grant1 !== 3'b001 || mem_enable1 !== 1'b1) begin errors++; $display("FAIL lat1_issue: got %b/%b expected 001/1", grant1, mem_enable1); end
      @(negedge clk);
      checks++; if (ack1 !== 3'b000 || busy1 !== 1'b1) begin errors++; $display("FAIL lat1_wait: got %b/%b expected 000/1", ack1, busy1); end
      @(negedge clk);
      checks++; if (ack1 !== 3'b001) begin errors++; $display("FAIL lat1_ack: got %b expected 001", ack1); end
      checks++; if (read_data1 !== 8'h2D) begin errors++; $display("FAIL lat1_data: got %h expected 2D", read_data1); end
      @(negedge clk);
      checks++; if (grant1 !== 3'b000 || ack1 !== 3'b000) begin errors++; $display("FAIL lat1_release: got %b/%b expected 000/000", grant1, ack1); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_round_robin();
      test_write_then_read();
      test_halt();
      test_reset_mid();
      test_latency1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
